// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles the signals exchanged between the 5-stage pipeline datapath and the
// hazard/sequencing controller.
//
// Parameters:
//   REG_W : register index width
//   CNT_W : performance counter width
//
// Signal groups:
//   ID stage   : id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md
//   EX stage   : ex_valid, ex_is_load, ex_rd, ex_redirect
//   mul/div    : md_done (in), md_start / md_abort (out), md_timeout (out)
//   pipeline   : pc_en, ifid_stall, ifid_flush, idex_flush
//   status     : state, stall_cnt, flush_cnt
//
// Modports:
//   master : pipeline/datapath side, drives hazard information
//   slave  : controller side, drives the pipeline controls
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_md;

  logic             ex_valid;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             ex_redirect;

  logic             md_done;

  logic             pc_en;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_start;
  logic             md_abort;
  logic             md_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md,
    output ex_valid, ex_is_load, ex_rd, ex_redirect,
    output md_done,
    input  pc_en, ifid_stall, ifid_flush, idex_flush,
    input  md_start, md_abort, md_timeout,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_md,
    input  ex_valid, ex_is_load, ex_rd, ex_redirect,
    input  md_done,
    output pc_en, ifid_stall, ifid_flush, idex_flush,
    output md_start, md_abort, md_timeout,
    output state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and sequencing controller for the 5-stage core. Resolves
// EX-stage branch redirects, load-use dependencies and multi-cycle mul/div
// occupancy by driving PC enable, IF/ID stall/flush and ID/EX bubble
// insertion. Keeps saturating stall and flush cycle counters.
//
// Parameters:
//   REG_W         : register index width
//   CNT_W         : performance counter width
//   REDIR_BUBBLES : extra IF/ID flush cycles after a redirect (1..7)
//   MD_TIMEOUT    : maximum MD_WAIT cycles before the watchdog fires
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : hazard_ctrl_if slave modport (hazard inputs, pipeline controls,
//           mul/div handshake, state and performance counters)
//
// Pipeline controls are combinational from the registered state and the
// current inputs, so every hazard response lands in the detection cycle.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W         = 5,
  parameter int CNT_W         = 32,
  parameter int REDIR_BUBBLES = 1,
  parameter int MD_TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REDIR   = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  localparam int              WD_W     = $clog2(MD_TIMEOUT + 1);
  localparam logic [2:0]      BUB_LOAD = 3'(REDIR_BUBBLES);
  // The watchdog holds the number of MD_WAIT cycles already completed, so the
  // MD_TIMEOUT-th waiting cycle is the one that sees MD_TIMEOUT-1.
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(MD_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       bub_q;
  logic [2:0]       bub_d;
  logic [WD_W-1:0]  wd_q;
  logic [WD_W-1:0]  wd_d;
  logic             tmo_q;
  logic             tmo_d;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic redir;
  logic lu;
  logic rs1_hit;
  logic rs2_hit;

  logic pc_en_c;
  logic stall_c;
  logic flush_c;
  logic idex_c;
  logic start_c;
  logic abort_c;

  logic pc_en_o;
  logic stall_o;
  logic flush_o;
  logic idex_o;
  logic start_o;
  logic abort_o;

  // Hazard detection terms
  assign redir   = bus.ex_valid & bus.ex_redirect;
  assign rs1_hit = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
  assign lu      = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != '0) &
                   bus.id_valid & (rs1_hit | rs2_hit);

  // Next state and raw controls. Redirect beats mul/div, which beats
  // load-use. REDIR ignores ID-stage hazards because IF/ID is being flushed.
  always_comb begin
    state_d = state_q;
    bub_d   = bub_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    pc_en_c = 1'b1;
    stall_c = 1'b0;
    flush_c = 1'b0;
    idex_c  = 1'b0;
    start_c = 1'b0;
    abort_c = 1'b0;

    case (state_q)
      RUN: begin
        if (redir) begin
          flush_c = 1'b1;
          idex_c  = 1'b1;
          state_d = REDIR;
          bub_d   = BUB_LOAD;
        end else if (bus.id_valid && bus.id_is_md) begin
          start_c = 1'b1;
          pc_en_c = 1'b0;
          stall_c = 1'b1;
          idex_c  = 1'b1;
          state_d = MD_WAIT;
          wd_d    = '0;
        end else if (lu) begin
          // One bubble is enough: the load leaves EX on the next edge.
          pc_en_c = 1'b0;
          stall_c = 1'b1;
          idex_c  = 1'b1;
        end
      end

      REDIR: begin
        flush_c = 1'b1;
        if (redir) begin
          idex_c = 1'b1;
          bub_d  = BUB_LOAD;
        end else begin
          bub_d = bub_q - 3'd1;
          if (bub_q <= 3'd1) begin
            state_d = RUN;
          end
        end
      end

      MD_WAIT: begin
        if (redir) begin
          abort_c = 1'b1;
          flush_c = 1'b1;
          idex_c  = 1'b1;
          state_d = REDIR;
          bub_d   = BUB_LOAD;
        end else if (bus.md_done) begin
          // Release with everything at default so the md op advances.
          state_d = RUN;
        end else if (wd_q == WD_LAST) begin
          abort_c = 1'b1;
          tmo_d   = 1'b1;
          state_d = RUN;
        end else begin
          pc_en_c = 1'b0;
          stall_c = 1'b1;
          idex_c  = 1'b1;
          wd_d    = wd_q + 1'b1;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // While reset is held the pipeline is kept frozen and filled with bubbles.
  // No md_abort here: the mul/div unit shares this reset.
  always_comb begin
    pc_en_o = pc_en_c;
    stall_o = stall_c & ~flush_c;
    flush_o = flush_c;
    idex_o  = idex_c;
    start_o = start_c;
    abort_o = abort_c;
    if (!reset) begin
      pc_en_o = 1'b0;
      stall_o = 1'b0;
      flush_o = 1'b1;
      idex_o  = 1'b1;
      start_o = 1'b0;
      abort_o = 1'b0;
    end
  end

  // State, bubble counter, watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      bub_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_o && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_o && !(&flush_q)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bus.pc_en      = pc_en_o;
  assign bus.ifid_stall = stall_o;
  assign bus.ifid_flush = flush_o;
  assign bus.idex_flush = idex_o;
  assign bus.md_start   = start_o;
  assign bus.md_abort   = abort_o;
  assign bus.md_timeout = tmo_q;
  assign bus.state      = state_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.flush_cnt  = flush_q;

endmodule
